// File: rtl/dbus_ram_responder_pkg.sv
// Shared data-bus request/response types for the core's data bus and its responders.
package dbus_ram_responder_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/byte_ram.sv
// Word-addressed RAM with per-byte write enables and an asynchronous read port.
// Contents are deliberately never reset.
module byte_ram #(
  parameter int unsigned Depth = 1024,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic [3:0]       be_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (be_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dbus_ram_responder.sv
// Fixed-latency RAM responder for the core's data bus; one request in flight at a time.
module dbus_ram_responder
  import dbus_ram_responder_pkg::*;
#(
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic       clk,
  input  logic       resetn,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int unsigned IdxW    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strobe_q, strobe_d;

  logic        addr_ok;
  logic        data_ok;
  logic [3:0]  be;
  logic [31:0] rdata;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    strobe_d = strobe_q;
    addr_ok  = 1'b0;
    data_ok  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dreq.valid) begin
          addr_ok  = 1'b1;
          addr_d   = dreq.addr;
          wdata_d  = dreq.data;
          strobe_d = dreq.strobe;
          cnt_d    = CntLoad;
          state_d  = (LATENCY == 1) ? StResp : StWait;
        end
      end
      StWait: begin
        // Leave one cycle early so data_ok lands exactly LATENCY cycles after addr_ok.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StResp;
        end
      end
      StResp: begin
        data_ok = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Reset abandons any pending request: no handshake, no write commit.
    if (!resetn) begin
      addr_ok = 1'b0;
      data_ok = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strobe_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      strobe_q <= strobe_d;
    end
  end

  assign be = data_ok ? strobe_q : 4'b0000;

  byte_ram #(
    .Depth(DEPTH_WORDS)
  ) u_byte_ram (
    .clk_i  (clk),
    .be_i   (be),
    .addr_i (addr_q[IdxW+1:2]),
    .wdata_i(wdata_q),
    .rdata_o(rdata)
  );

  assign dresp.addr_ok = addr_ok;
  assign dresp.data_ok = data_ok;
  assign dresp.data    = data_ok ? rdata : 32'h0;

  // Size is not interpreted and address bits outside the word index are ignored.
  logic unused_bits;
  assign unused_bits = ^{dreq.size, addr_q[31:IdxW+2], addr_q[1:0]};

endmodule

// File: doc/dbus_ram_responder.md
DBUS_RAM_RESPONDER -- requirements
Module: dbus_ram_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning cycles from address handshake to data handshake (legal range 1..15).
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words stored (power of two).
REQ-003 SHALL have port clk, input, 1, the clock.
REQ-004 SHALL have port resetn, input, 1, the synchronous active-low reset.
REQ-005 SHALL have port dreq, input, dbus_req_t: valid, addr[31:0], size, strobe[3:0], data[31:0].
REQ-006 SHALL have port dresp, output, dbus_resp_t: addr_ok, data_ok, data[31:0].

Function
REQ-007 SHALL act as the responder end of the core's data bus, with one outstanding request at a time.
REQ-008 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-009 SHALL drive addr_ok combinationally as (state==IDLE && dreq.valid); addr_ok is never asserted in WAIT or RESP.
REQ-010 SHALL, on the addr_ok cycle edge, latch addr, strobe and data into request registers and load the latency counter with LATENCY-1.
REQ-011 SHALL move from IDLE to RESP when LATENCY==1, and to WAIT otherwise.
REQ-012 SHALL decrement the counter by one each cycle in WAIT and enter RESP when the counter reaches 0.
REQ-013 SHALL assert data_ok for exactly one cycle in RESP, then return to IDLE; the next addr_ok comes no earlier than the cycle after data_ok.
REQ-014 SHALL give data_ok at cycle T+LATENCY for an addr_ok at cycle T; throughput is one request per LATENCY+1 cycles.
REQ-015 SHALL form the word index from latched addr[log2(DEPTH_WORDS)+1:2], with higher address bits ignored (wrap-around modulo DEPTH_WORDS).
REQ-016 SHALL treat strobe==0 as a read: in RESP, dresp.data equals the stored word at the index.
REQ-017 SHALL treat strobe!=0 as a write: on the RESP cycle edge, byte lane i is updated from data[8i+7:8i] only where strobe[i]==1; dresp.data in RESP is the pre-write word.
REQ-018 SHALL return the written value to a read issued after a write's data_ok, with no hazard window.
REQ-019 SHALL drive dresp.data to 0 in any cycle where data_ok==0.
REQ-020 SHALL ignore dreq fields outside the addr_ok cycle; changes to dreq during WAIT or RESP have no effect.
REQ-021 SHALL not interpret size; byte placement is governed by strobe alone.

Reset
REQ-022 SHALL, when resetn==0 at a clk edge, set state=IDLE, counter=0 and request registers=0, with addr_ok=0, data_ok=0 and data=0 in the following cycle when dreq.valid==0.
REQ-023 SHALL, on reset mid-operation (WAIT or RESP), abandon the pending request without committing any write and without asserting data_ok.
REQ-024 SHALL leave memory contents unchanged by reset, with no initialisation required.
REQ-025 SHALL force addr_ok=0 while resetn==0.

Structure
REQ-026 SHALL take dbus_req_t and dbus_resp_t from the shared common package; no new typedefs are added there.
REQ-027 SHALL keep the FSM state enum local to the module.
REQ-028 SHALL instantiate one sub-module, byte_ram: a DEPTH_WORDS x 32 array with a 4-bit byte write enable and an asynchronous read port.

Verification
REQ-029 SHALL cover write then read: write addr=0x10, data=0xDEADBEEF, strobe=4'hF, then read 0x10 with LATENCY=2 -> addr_ok at T, data_ok at T+2, data=0xDEADBEEF.
REQ-030 SHALL cover partial strobe: over 0x11223344 at 0x20, write data=0xAABBCCDD, strobe=4'b0101, then read -> 0x11BB33DD.
REQ-031 SHALL cover wrap-around: DEPTH_WORDS=1024, write 0x5 at addr 0x1000, then read addr 0x0 -> 0x00000005.
REQ-032 SHALL cover latency and stability: LATENCY=1 with valid held high continuously -> addr_ok at cycles 0, 2, 4, data_ok at cycles 1, 3, 5; dreq changes during WAIT have no effect on the result.
REQ-033 SHALL cover reset mid-write: resetn low in WAIT of a write to 0x30 -> no data_ok, and a subsequent read of 0x30 returns the old value.
REQ-034 SHALL cover idle behaviour: valid=0 for 10 cycles -> addr_ok=0, data_ok=0 and data=0 throughout.
